// File: rtl/hog_frame_ctrl.sv
// hog_frame_ctrl: frame-level scheduler in front of the hog_svm pipeline.
// Fetches FRAME_WORDS pixel words per frame and hands them to the pipeline
// over the request/ready handshake. It also counts scored slide windows and
// queues positive detections in a small FIFO for the host.
// Optional drain watchdog: define HOG_FRAME_CTRL_TIMEOUT_EN to compile it in.
module hog_frame_ctrl #(
    parameter int PIX_W       = 8,
    parameter int PIX_N       = 96,
    parameter int ADDR_W      = 16,
    parameter int FRAME_WORDS = 200,
    parameter int SW_W        = 11,
    parameter int SW_N        = 105,
    parameter int RES_W       = 32,
    parameter int FIFO_D      = 8,
    parameter int TO_CYC      = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_rd,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_rvalid,
    input  logic [PIX_W*PIX_N-1:0] mem_rdata,
    input  logic                   hog_request,
    output logic                   hog_ready,
    output logic [PIX_W*PIX_N-1:0] hog_data,
    input  logic                   svm_valid,
    input  logic                   svm_is_person,
    input  logic [RES_W-1:0]       svm_result,
    input  logic [SW_W-1:0]        svm_sw_id,
    output logic                   det_valid,
    input  logic                   det_ready,
    output logic [SW_W-1:0]        det_sw_id,
    output logic [RES_W-1:0]       det_score,
    output logic [7:0]             det_count,
    output logic                   overflow,
    output logic                   timeout
);

    localparam int DATA_W = PIX_W * PIX_N;
    localparam int ENT_W  = SW_W + RES_W;
    localparam int PTR_W  = $clog2(FIFO_D);
    localparam int WC_W   = $clog2(FRAME_WORDS + 1);

    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(FRAME_WORDS - 1);
    localparam logic [SW_W:0]   SW_N_L    = (SW_W + 1)'(SW_N);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_REQ = 3'd1;
    localparam logic [2:0] ST_WAIT_MEM = 3'd2;
    localparam logic [2:0] ST_SEND     = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [SW_W-1:0]   win_cnt_q, win_cnt_d;
    logic              mem_rd_q, mem_rd_d;
    logic [DATA_W-1:0] hog_data_q, hog_data_d;
    logic [SW_W:0]     win_ext;
    logic              win_reached;
    logic              frame_active;
    logic              start_acc;

`ifdef HOG_FRAME_CTRL_TIMEOUT_EN
    localparam int            TO_W    = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
`else
    localparam int unused_to_cyc = TO_CYC;
`endif

    logic [ENT_W-1:0]  fifo_mem [FIFO_D];
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    logic              fifo_empty, fifo_full;
    logic              push_req, push_ok, pop;
    logic [7:0]        det_count_q;
    logic              overflow_q;

    assign frame_active = (state_q == ST_WAIT_REQ) || (state_q == ST_WAIT_MEM) ||
                          (state_q == ST_SEND)     || (state_q == ST_DRAIN);
    assign start_acc    = (state_q == ST_IDLE) && start;

    // A window count already at SW_N (or reaching it now) ends the drain; the
    // >= form keeps the frame from stalling if windows finish before the fetch.
    assign win_ext     = {1'b0, win_cnt_q};
    assign win_reached = (win_ext >= SW_N_L) || (svm_valid && ((win_ext + 1'b1) >= SW_N_L));

    // Next-state logic for the fetch/drain sequencer and its counters
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_cnt_d = word_cnt_q;
        win_cnt_d  = win_cnt_q;
        mem_rd_d   = 1'b0;
        hog_data_d = hog_data_q;
`ifdef HOG_FRAME_CTRL_TIMEOUT_EN
        to_cnt_d   = '0;
        timeout_d  = timeout_q;
`endif
        if (frame_active && svm_valid) begin
            win_cnt_d = win_cnt_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_WAIT_REQ;
                    addr_d     = base_addr;
                    word_cnt_d = '0;
                    win_cnt_d  = '0;
`ifdef HOG_FRAME_CTRL_TIMEOUT_EN
                    timeout_d  = 1'b0;
`endif
                end
            end
            ST_WAIT_REQ: begin
                if (hog_request) begin
                    mem_rd_d = 1'b1;
                    state_d  = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    hog_data_d = mem_rdata;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                addr_d     = addr_q + 1'b1;
                word_cnt_d = word_cnt_q + 1'b1;
                state_d    = (word_cnt_q == LAST_WORD) ? ST_DRAIN : ST_WAIT_REQ;
            end
            ST_DRAIN: begin
                if (win_reached) begin
                    state_d = ST_DONE;
                end
`ifdef HOG_FRAME_CTRL_TIMEOUT_EN
                else if (svm_valid) begin
                    to_cnt_d = TO_W'(1);
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers, cleared by reset so any frame is aborted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            word_cnt_q <= '0;
            win_cnt_q  <= '0;
            mem_rd_q   <= 1'b0;
            hog_data_q <= '0;
`ifdef HOG_FRAME_CTRL_TIMEOUT_EN
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_cnt_q <= word_cnt_d;
            win_cnt_q  <= win_cnt_d;
            mem_rd_q   <= mem_rd_d;
            hog_data_q <= hog_data_d;
`ifdef HOG_FRAME_CTRL_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop        = !fifo_empty && det_ready;
    assign push_req   = frame_active && svm_valid && svm_is_person;
    assign push_ok    = push_req && (!fifo_full || pop);

    // Detection FIFO pointers plus the per-frame positive count and drop flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            det_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (start_acc) begin
                det_count_q <= '0;
                overflow_q  <= 1'b0;
            end else if (push_req) begin
                if (det_count_q != 8'hFF) begin
                    det_count_q <= det_count_q + 1'b1;
                end
                if (!push_ok) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    // FIFO storage; contents need no reset because the head is masked when empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {svm_sw_id, svm_result};
        end
    end

    assign busy      = frame_active;
    assign done      = (state_q == ST_DONE);
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = addr_q;
    assign hog_ready = (state_q == ST_SEND);
    assign hog_data  = hog_data_q;
    assign det_valid = !fifo_empty;
    assign {det_sw_id, det_score} = fifo_empty ? '0 : fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign det_count = det_count_q;
    assign overflow  = overflow_q;
`ifdef HOG_FRAME_CTRL_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_hog_frame_ctrl.sv
// tb_hog_frame_ctrl: directed bench for hog_frame_ctrl with a small frame
// (4 words, 2 windows, 16-cycle watchdog) and a fixed-latency memory model.
`timescale 1ns/1ps
module tb_hog_frame_ctrl;

    localparam int PIX_W       = 8;
    localparam int PIX_N       = 4;
    localparam int ADDR_W      = 16;
    localparam int FRAME_WORDS = 4;
    localparam int SW_W        = 11;
    localparam int SW_N        = 2;
    localparam int RES_W       = 32;
    localparam int FIFO_D      = 8;
    localparam int TO_CYC      = 16;
    localparam int DATA_W      = PIX_W * PIX_N;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              busy, done, mem_rd, hog_ready, det_valid, overflow, timeout;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              hog_request = 1'b0;
    logic [DATA_W-1:0] hog_data;
    logic              svm_valid = 1'b0;
    logic              svm_is_person = 1'b0;
    logic [RES_W-1:0]  svm_result = '0;
    logic [SW_W-1:0]   svm_sw_id = '0;
    logic              det_ready = 1'b0;
    logic [SW_W-1:0]   det_sw_id;
    logic [RES_W-1:0]  det_score;
    logic [7:0]        det_count;

    int                compareCount = 0;
    int                mismatchCount = 0;
    int                memLatency = 3;
    int                rdCount = 0;
    int                readyCount = 0;
    logic [ADDR_W-1:0] nextRdAddr = '0;
    logic [ADDR_W-1:0] nextDataAddr = '0;
    logic [ADDR_W-1:0] memReqAddr = '0;
    logic              lastRvalid = 1'b0;

    hog_frame_ctrl #(
        .PIX_W(PIX_W), .PIX_N(PIX_N), .ADDR_W(ADDR_W), .FRAME_WORDS(FRAME_WORDS),
        .SW_W(SW_W), .SW_N(SW_N), .RES_W(RES_W), .FIFO_D(FIFO_D), .TO_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .hog_request(hog_request), .hog_ready(hog_ready), .hog_data(hog_data),
        .svm_valid(svm_valid), .svm_is_person(svm_is_person),
        .svm_result(svm_result), .svm_sw_id(svm_sw_id),
        .det_valid(det_valid), .det_ready(det_ready), .det_sw_id(det_sw_id),
        .det_score(det_score), .det_count(det_count),
        .overflow(overflow), .timeout(timeout)
    );

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    // Pixel word stored at each frame buffer address, recognisable per address
    function automatic logic [DATA_W-1:0] wordOf(input logic [ADDR_W-1:0] a);
        return {a ^ 16'hA5A5, a};
    endfunction

    // Single comparison point: counts every check and reports any mismatch
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Frame buffer model: answers each read strobe memLatency cycles later
    initial begin
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                memReqAddr = mem_addr;
                repeat (memLatency) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = wordOf(memReqAddr);
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
            end
        end
    end

    // Bus monitor: read addresses must be sequential, each hog_ready must follow
    // a read return by one cycle and carry the word for the next expected address
    initial begin
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                rdCount++;
                checkOutput("memAddr", mem_addr, nextRdAddr);
                nextRdAddr++;
            end
            if (hog_ready === 1'b1) begin
                readyCount++;
                checkOutput("readyAfterRvalid", lastRvalid, 1);
                checkOutput("hogData", hog_data, wordOf(nextDataAddr));
                nextDataAddr++;
            end
            lastRvalid = mem_rvalid;
        end
    end

    // Safety net so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL globalTimeout: got still running, expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // One svm_valid pulse, optionally with a host pop in the same cycle
    task automatic applyStimulus(input logic isPerson, input int swId,
                                 input logic [RES_W-1:0] score, input logic popToo);
        @(negedge clk);
        svm_valid     = 1'b1;
        svm_is_person = isPerson;
        svm_sw_id     = SW_W'(swId);
        svm_result    = score;
        det_ready     = popToo;
        @(posedge clk);
        #1;
        svm_valid     = 1'b0;
        svm_is_person = 1'b0;
        det_ready     = 1'b0;
    endtask

    // Pop the FIFO head for one cycle
    task automatic popOne();
        @(negedge clk);
        det_ready = 1'b1;
        @(posedge clk);
        #1;
        det_ready = 1'b0;
    endtask

    // Issue an accepted start and confirm busy follows a cycle later
    task automatic startFrame(input logic [ADDR_W-1:0] base);
        nextRdAddr   = base;
        nextDataAddr = base;
        rdCount      = 0;
        readyCount   = 0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busyAfterStart", busy, 1);
    endtask

    // Wait (bounded) until n words have been handed to the pipeline
    task automatic waitWords(input int n);
        for (int i = 0; i < 400 && readyCount < n; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("wordsSent", readyCount, n);
    endtask

    // Wait (bounded) until the controller is sitting in a hog_ready cycle
    task automatic waitHogReady();
        for (int i = 0; i < 400 && hog_ready !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("reachedSend", hog_ready, 1);
    endtask

    // Pull reset low right now (asynchronously), hold two cycles, release
    task automatic pulseReset();
        rst = 1'b0;
        #1;
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstHogReady", hog_ready, 0);
        checkOutput("rstDetValid", det_valid, 0);
        checkOutput("rstDetCount", det_count, 0);
        checkOutput("rstOverflow", overflow, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Directed scenario sequence
    initial begin
        int  k;
        logic doneSeen;

        // Power-on reset values
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        checkOutput("resetMemRd", mem_rd, 0);
        checkOutput("resetMemAddr", mem_addr, 0);
        checkOutput("resetHogReady", hog_ready, 0);
        checkOutput("resetHogData", hog_data, 0);
        checkOutput("resetDetValid", det_valid, 0);
        checkOutput("resetDetSwId", det_sw_id, 0);
        checkOutput("resetDetCount", det_count, 0);
        checkOutput("resetOverflow", overflow, 0);
        checkOutput("resetTimeout", timeout, 0);
        @(negedge clk);
        rst = 1'b1;

        // Reset in the middle of a frame with detections queued
        hog_request = 1'b1;
        startFrame(16'h0040);
        applyStimulus(1'b1, 3, 32'h0000_AAAA, 1'b0);
        applyStimulus(1'b1, 4, 32'h0000_BBBB, 1'b0);
        checkOutput("preRstDetCount", det_count, 2);
        checkOutput("preRstDetValid", det_valid, 1);
        waitHogReady();
        pulseReset();

        // Normal frame: four words from 0x0100, then both windows scored
        startFrame(16'h0100);
        waitWords(4);
        checkOutput("readCount", rdCount, 4);
        checkOutput("drainBusy", busy, 1);
        checkOutput("drainNoDone", done, 0);
        applyStimulus(1'b1, 5, 32'h0000_1234, 1'b0);
        checkOutput("oneWindowNoDone", done, 0);
        applyStimulus(1'b0, 6, 32'h0000_0099, 1'b0);
        checkOutput("doneLatency", done, 1);
        checkOutput("busyDropsWithDone", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("doneOneCycle", done, 0);
        checkOutput("idleBusy", busy, 0);
        checkOutput("headSwId", det_sw_id, 5);
        checkOutput("headScore", det_score, 32'h0000_1234);
        checkOutput("frameDetCount", det_count, 1);
        popOne();
        checkOutput("emptyAfterPop", det_valid, 0);
        checkOutput("emptySwId", det_sw_id, 0);
        checkOutput("emptyScore", det_score, 0);
        checkOutput("noExtraReads", rdCount, 4);

        // Stalled pipeline: FIFO filling, simultaneous push/pop, then overflow
        hog_request = 1'b0;
        startFrame(16'h0200);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 10 + i, RES_W'(32'h100 + 10 + i), 1'b0);
        end
        checkOutput("fillDetCount", det_count, 8);
        checkOutput("fillNoOverflow", overflow, 0);
        checkOutput("fillHead", det_sw_id, 10);
        checkOutput("fillHeadScore", det_score, 32'h10A);
        applyStimulus(1'b1, 18, 32'h112, 1'b1);
        checkOutput("pushPopNoOverflow", overflow, 0);
        checkOutput("pushPopDetCount", det_count, 9);
        checkOutput("pushPopHead", det_sw_id, 11);
        for (int i = 0; i < 8; i++) begin
            checkOutput("popOrderA", det_sw_id, 11 + i);
            popOne();
        end
        checkOutput("depthAfterPushPop", det_valid, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 30 + i, RES_W'(32'h200 + i), 1'b0);
        end
        checkOutput("ovfDetCount", det_count, 19);
        checkOutput("ovfFlag", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("popOrderB", det_sw_id, 30 + i);
            popOne();
        end
        checkOutput("depthAfterOverflow", det_valid, 0);
        checkOutput("ovfSticky", overflow, 1);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("stallNoRead", rdCount, 0);
        checkOutput("stallNoReady", readyCount, 0);
        @(negedge clk);
        hog_request = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("resumeMemRd", mem_rd, 1);
        checkOutput("resumeAddr", mem_addr, 16'h0200);
        @(posedge clk);
        #1;
        checkOutput("memRdOneCycle", mem_rd, 0);
        waitHogReady();
        pulseReset();

        // Drain with only one of the two windows scored
        startFrame(16'h0300);
        waitWords(4);
        applyStimulus(1'b0, 1, 32'h5, 1'b0);
        k = 1;
        doneSeen = (done === 1'b1);
        while (!doneSeen && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            doneSeen = (done === 1'b1);
        end
`ifdef HOG_FRAME_CTRL_TIMEOUT_EN
        checkOutput("timeoutDoneCycle", k, 16);
        checkOutput("timeoutFlag", timeout, 1);
        checkOutput("busyAtTimeout", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("timeoutDoneOnce", done, 0);
        checkOutput("timeoutSticky", timeout, 1);
`else
        checkOutput("noWatchdogDone", doneSeen, 0);
        checkOutput("busyHeld", busy, 1);
        checkOutput("timeoutTied", timeout, 0);
        applyStimulus(1'b0, 2, 32'h6, 1'b0);
        checkOutput("lateWindowDone", done, 1);
        checkOutput("lateWindowBusy", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
